// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared types for the tiled-matmul sequencer
// Contents:
//   seq_state_t : sequencer FSM states
//   out_phase_t : compute-window phase (array filling vs. results draining)
package tpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        WAIT_ACT,
        COMPUTE,
        FINISH
    } seq_state_t;

    typedef enum logic {
        FILL,
        OUT
    } out_phase_t;

endpackage

// File: rtl/lane_mask_gen.sv
// rtl/lane_mask_gen.sv - per-lane accumulator write mask for one output step
// Purpose: lane j holds a valid result at output step o when the skewed
//          wavefront has reached it (j <= o) and has not yet run past the
//          last activation row (o - j < h_rows).
// Ports:
//   o_i      in  OW         output step within the drain phase
//   h_rows_i in  ROW_W      activation rows of the current command
//   mask_o   out ARRAY_DIM  lane mask, MSB = lane 0
module lane_mask_gen #(
    parameter int ARRAY_DIM = 32,
    parameter int ROW_W     = 9,
    parameter int OW        = 16
) (
    input  logic [OW-1:0]        o_i,
    input  logic [ROW_W-1:0]     h_rows_i,
    output logic [ARRAY_DIM-1:0] mask_o
);

    always_comb begin
        mask_o = '0;
        for (int j = 0; j < ARRAY_DIM; j++) begin
            mask_o[ARRAY_DIM-1-j] = (OW'(j) <= o_i) && ((o_i - OW'(j)) < OW'(h_rows_i));
        end
    end

endmodule

// File: rtl/tile_sequencer.sv
// rtl/tile_sequencer.sv - tiled-matmul sequencer for the systolic MAC array
// Purpose: walks N-tiles (outer) x K-tiles (inner), driving weight loads,
//          activation streaming, array compute and accumulator access.
//          Optional double-buffered weight prefetch during the drain phase.
// Ports:
//   clk_i, rst_i (sync, active-low)
//   start_i, H_ROWS_i, K_TILES_i, N_TILES_i    command (dims sampled on start_i)
//   weight_valid_i, activations_rdy_i          upstream status
//   busy_o, done_o, error_o                    command handshake
//   load_weights_o, swap_weights_o             weight FIFO / shadow buffer control
//   load_activations_o, mac_compute_o          array control
//   acc_read_o, acc_write_o, acc_add_o,
//   acc_addr_rd_o, acc_addr_wr_o, acc_mask_o   accumulator bank control
// All outputs come straight from flops.
module tile_sequencer
    import tpu_pkg::*;
#(
    parameter int ARRAY_DIM = 32,
    parameter int ACC_DEPTH = 128,
    parameter int ROW_W     = 9,
    parameter int TILE_W    = 4,
    parameter int PREFETCH  = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic [ROW_W-1:0]             H_ROWS_i,
    input  logic [TILE_W-1:0]            K_TILES_i,
    input  logic [TILE_W-1:0]            N_TILES_i,
    input  logic                         weight_valid_i,
    input  logic                         activations_rdy_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         error_o,
    output logic                         load_weights_o,
    output logic                         swap_weights_o,
    output logic                         load_activations_o,
    output logic                         mac_compute_o,
    output logic                         acc_read_o,
    output logic                         acc_write_o,
    output logic                         acc_add_o,
    output logic [$clog2(ACC_DEPTH)-1:0] acc_addr_rd_o,
    output logic [$clog2(ACC_DEPTH)-1:0] acc_addr_wr_o,
    output logic [ARRAY_DIM-1:0]         acc_mask_o
);

    localparam int AW = $clog2(ACC_DEPTH);
    localparam int SW = ROW_W + $clog2(ARRAY_DIM) + 1;   // holds H + ARRAY_DIM - 1
    localparam int CW = SW + 1;                          // holds ARRAY_DIM + stride
    localparam int PW = SW + TILE_W + 1;                 // (N+1) * stride
    localparam int DW = $clog2(ARRAY_DIM + 1);           // weight beats 0..ARRAY_DIM

    seq_state_t        state_q, state_d;
    logic [DW-1:0]     wbeat_q, wbeat_d, beats_now;
    logic [CW-1:0]     c_q, c_d, o_d, end_c;
    logic [TILE_W-1:0] k_q, k_d, n_q, n_d, kt_q, kt_d, nt_q, nt_d;
    logic [AW-1:0]     base_q, base_d;
    logic [ROW_W-1:0]  h_q, h_d;
    logic [SW-1:0]     stride_q, stride_d, stride_in;
    logic [PW-1:0]     footprint;
    logic              last_tile;

    logic              busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic              ldw_q, ldw_d, swap_q, swap_d, lda_q, lda_d, mac_q, mac_d;
    logic              rd_q, rd_d, wr_q, wr_d, add_q, add_d;
    logic [AW-1:0]     addr_rd_q, addr_rd_d, addr_wr_q, addr_wr_d;
    logic [ARRAY_DIM-1:0] mask_q, mask_d, mask_w;
    out_phase_t        phase_d;
    logic              in_comp;

    // Next state and counters.
    always_comb begin
        state_d  = state_q;
        wbeat_d  = wbeat_q;
        c_d      = c_q;
        k_d      = k_q;
        n_d      = n_q;
        kt_d     = kt_q;
        nt_d     = nt_q;
        base_d   = base_q;
        h_d      = h_q;
        stride_d = stride_q;
        swap_d   = 1'b0;
        error_d  = 1'b0;

        beats_now = wbeat_q + DW'(ldw_q & weight_valid_i);
        stride_in = SW'(H_ROWS_i) + SW'(ARRAY_DIM - 1);
        footprint = (PW'(N_TILES_i) + PW'(1)) * PW'(stride_in);
        last_tile = (k_q == kt_q) && (n_q == nt_q);
        end_c     = CW'(ARRAY_DIM) + CW'(stride_q) - CW'(1);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (H_ROWS_i == '0 || footprint > PW'(ACC_DEPTH)) begin
                        error_d = 1'b1;
                    end else begin
                        h_d      = H_ROWS_i;
                        kt_d     = K_TILES_i;
                        nt_d     = N_TILES_i;
                        stride_d = stride_in;
                        k_d      = '0;
                        n_d      = '0;
                        base_d   = '0;
                        wbeat_d  = '0;
                        state_d  = LOAD_W;
                    end
                end
            end
            LOAD_W: begin
                wbeat_d = beats_now;
                if (beats_now == DW'(ARRAY_DIM)) begin
                    wbeat_d = '0;
                    swap_d  = 1'b1;
                    state_d = WAIT_ACT;
                end
            end
            WAIT_ACT: begin
                if (activations_rdy_i) begin
                    c_d     = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                c_d     = c_q + CW'(1);
                wbeat_d = beats_now;   // only moves while prefetching
                if (c_q == end_c) begin
                    c_d = '0;
                    if (last_tile) begin
                        k_d     = '0;
                        n_d     = '0;
                        base_d  = '0;
                        wbeat_d = '0;
                        state_d = FINISH;
                    end else begin
                        if (k_q != kt_q) begin
                            k_d = k_q + TILE_W'(1);
                        end else begin
                            k_d    = '0;
                            n_d    = n_q + TILE_W'(1);
                            base_d = base_q + AW'(stride_q);
                        end
                        if (PREFETCH != 0 && beats_now == DW'(ARRAY_DIM)) begin
                            wbeat_d = '0;
                            swap_d  = 1'b1;
                            state_d = WAIT_ACT;
                        end else begin
                            // Serial mode starts a fresh load; prefetch mode
                            // resumes the partially received tile.
                            state_d = LOAD_W;
                        end
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_d = c_d - CW'(ARRAY_DIM);

    lane_mask_gen #(
        .ARRAY_DIM (ARRAY_DIM),
        .ROW_W     (ROW_W),
        .OW        (CW)
    ) u_mask (
        .o_i      (o_d),
        .h_rows_i (h_d),
        .mask_o   (mask_w)
    );

    // Output decode from next state so every output is a flop aligned with state_q.
    always_comb begin
        phase_d   = (c_d < CW'(ARRAY_DIM)) ? FILL : OUT;
        in_comp   = (state_d == COMPUTE);
        busy_d    = (state_d == LOAD_W) || (state_d == WAIT_ACT) || in_comp;
        done_d    = (state_d == FINISH);
        // Prefetch is skipped on the last tile: there is no next tile to load.
        ldw_d     = (state_d == LOAD_W) ||
                    (PREFETCH != 0 && in_comp && phase_d == OUT &&
                     wbeat_d < DW'(ARRAY_DIM) && !last_tile);
        lda_d     = (state_d == WAIT_ACT) || in_comp;
        mac_d     = in_comp;
        wr_d      = in_comp && (phase_d == OUT);
        add_d     = wr_d && (k_d != '0);
        rd_d      = add_d;
        addr_wr_d = wr_d ? AW'(CW'(base_d) + o_d) : '0;
        addr_rd_d = wr_d ? AW'(CW'(base_d) + o_d + CW'(1)) : '0;
        mask_d    = wr_d ? mask_w : '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            wbeat_q   <= '0;
            c_q       <= '0;
            k_q       <= '0;
            n_q       <= '0;
            kt_q      <= '0;
            nt_q      <= '0;
            base_q    <= '0;
            h_q       <= '0;
            stride_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            ldw_q     <= 1'b0;
            swap_q    <= 1'b0;
            lda_q     <= 1'b0;
            mac_q     <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            add_q     <= 1'b0;
            addr_rd_q <= '0;
            addr_wr_q <= '0;
            mask_q    <= '0;
        end else begin
            state_q   <= state_d;
            wbeat_q   <= wbeat_d;
            c_q       <= c_d;
            k_q       <= k_d;
            n_q       <= n_d;
            kt_q      <= kt_d;
            nt_q      <= nt_d;
            base_q    <= base_d;
            h_q       <= h_d;
            stride_q  <= stride_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            ldw_q     <= ldw_d;
            swap_q    <= swap_d;
            lda_q     <= lda_d;
            mac_q     <= mac_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            add_q     <= add_d;
            addr_rd_q <= addr_rd_d;
            addr_wr_q <= addr_wr_d;
            mask_q    <= mask_d;
        end
    end

    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign error_o            = error_q;
    assign load_weights_o     = ldw_q;
    assign swap_weights_o     = swap_q;
    assign load_activations_o = lda_q;
    assign mac_compute_o      = mac_q;
    assign acc_read_o         = rd_q;
    assign acc_write_o        = wr_q;
    assign acc_add_o          = add_q;
    assign acc_addr_rd_o      = addr_rd_q;
    assign acc_addr_wr_o      = addr_wr_q;
    assign acc_mask_o         = mask_q;

endmodule

// File: tb/tb_tile_sequencer.sv
// tb/tb_tile_sequencer.sv - scoreboard bench for tile_sequencer (serial and prefetch builds)
module tb_tile_sequencer;

    localparam int AD    = 32;
    localparam int DEPTH = 128;

    typedef struct packed {
        logic [6:0]  wa;
        logic [6:0]  ra;
        logic [31:0] mask;
        logic        add;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [8:0] h_in = '0;
    logic [3:0] k_in = '0;
    logic [3:0] n_in = '0;
    logic       wv = 1'b0;
    logic       ar = 1'b0;

    logic [1:0]  busy, done, err, ldw, swp, lda, mac, rd, wr, add;
    logic [6:0]  ard [2];
    logic [6:0]  awr [2];
    logic [31:0] msk [2];

    int compared   = 0;
    int mismatched = 0;
    int accepted   = 0;
    int done_cnt [2] = '{0, 0};
    int swap_cnt [2] = '{0, 0};
    int beat_cnt [2] = '{0, 0};
    int err_cnt  [2] = '{0, 0};
    exp_t q0 [$];
    exp_t q1 [$];
    bit stall = 1'b0;

    always #5 clk = ~clk;

    tile_sequencer #(.PREFETCH(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .H_ROWS_i(h_in), .K_TILES_i(k_in),
        .N_TILES_i(n_in), .weight_valid_i(wv), .activations_rdy_i(ar),
        .busy_o(busy[0]), .done_o(done[0]), .error_o(err[0]), .load_weights_o(ldw[0]),
        .swap_weights_o(swp[0]), .load_activations_o(lda[0]), .mac_compute_o(mac[0]),
        .acc_read_o(rd[0]), .acc_write_o(wr[0]), .acc_add_o(add[0]),
        .acc_addr_rd_o(ard[0]), .acc_addr_wr_o(awr[0]), .acc_mask_o(msk[0]));

    tile_sequencer #(.PREFETCH(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .H_ROWS_i(h_in), .K_TILES_i(k_in),
        .N_TILES_i(n_in), .weight_valid_i(wv), .activations_rdy_i(ar),
        .busy_o(busy[1]), .done_o(done[1]), .error_o(err[1]), .load_weights_o(ldw[1]),
        .swap_weights_o(swp[1]), .load_activations_o(lda[1]), .mac_compute_o(mac[1]),
        .acc_read_o(rd[1]), .acc_write_o(wr[1]), .acc_add_o(add[1]),
        .acc_addr_rd_o(ard[1]), .acc_addr_wr_o(awr[1]), .acc_mask_o(msk[1]));

    // Random upstream behaviour, changed just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            wv = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
            ar = ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: event counters and write scoreboard, sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (done[d]) begin
                    done_cnt[d]++;
                    compared++;
                    if (busy[d]) begin
                        mismatched++;
                        $display("FAIL done_busy dut%0d: busy_o=1 with done_o, required 0", d);
                    end
                end
                if (swp[d]) swap_cnt[d]++;
                if (err[d]) err_cnt[d]++;
                if (ldw[d] && wv) beat_cnt[d]++;
                if (wr[d]) begin
                    compared++;
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        mismatched++;
                        $display("FAIL unexpected_write dut%0d: wr=%0d with empty scoreboard", d, awr[d]);
                    end else begin
                        if (d == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        if ({awr[d], ard[d], msk[d], add[d], rd[d]} != {e.wa, e.ra, e.mask, e.add, e.add}) begin
                            mismatched++;
                            $display("FAIL write dut%0d: got wa=%0d ra=%0d mask=%h add=%0d rd=%0d, expected wa=%0d ra=%0d mask=%h add=%0d rd=%0d",
                                     d, awr[d], ard[d], msk[d], add[d], rd[d], e.wa, e.ra, e.mask, e.add, e.add);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int d, input longint got, input longint expv);
        compared++;
        if (got != expv) begin
            mismatched++;
            $display("FAIL %s dut%0d: got %0d expected %0d", name, d, got, expv);
        end
    endtask

    // Reference: every write of a command, in order, from the tile walk arithmetic.
    task automatic push_cmd(input int h, input int k, input int n);
        exp_t e;
        int   stride;
        stride = h + AD - 1;
        for (int nn = 0; nn <= n; nn++) begin
            for (int kk = 0; kk <= k; kk++) begin
                for (int o = 0; o < stride; o++) begin
                    e.wa   = 7'((nn * stride + o) % DEPTH);
                    e.ra   = 7'((nn * stride + o + 1) % DEPTH);
                    e.add  = (kk != 0);
                    e.mask = '0;
                    for (int j = 0; j < AD; j++) begin
                        if (j <= o && (o - j) < h) e.mask[AD-1-j] = 1'b1;
                    end
                    q0.push_back(e);
                    q1.push_back(e);
                end
            end
        end
    endtask

    task automatic issue(input int h, input int k, input int n);
        @(posedge clk);
        #1;
        start = 1'b1;
        h_in  = 9'(h);
        k_in  = 4'(k);
        n_in  = 4'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic chk_zero(input int d);
        chk("reset_outputs", d,
            longint'({busy[d], done[d], err[d], ldw[d], swp[d], lda[d], mac[d], rd[d], wr[d], add[d],
                      ard[d], awr[d], msk[d]}), 0);
    endtask

    task automatic run_cmd(input int h, input int k, input int n, input bit do_stall, input bit poke);
        int b_done [2];
        int b_swap [2];
        int b_beat [2];
        int b_err  [2];
        int tiles;
        int cyc;
        bit stalled;
        tiles = (k + 1) * (n + 1);
        for (int d = 0; d < 2; d++) begin
            b_done[d] = done_cnt[d];
            b_swap[d] = swap_cnt[d];
            b_beat[d] = beat_cnt[d];
            b_err[d]  = err_cnt[d];
        end
        push_cmd(h, k, n);
        issue(h, k, n);
        cyc = 0;
        stalled = 1'b0;
        while (!(done_cnt[0] > b_done[0] && done_cnt[1] > b_done[1]) && cyc < 20000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (do_stall && !stalled && ldw[1] && mac[1]) begin
                stall = 1'b1;
                repeat (200) @(posedge clk);
                #1;
                cyc += 200;
                chk("stall_in_load_w", 1, longint'({ldw[1], mac[1], busy[1]}), 3'b101);
                stall = 1'b0;
                stalled = 1'b1;
            end
            if (poke && cyc == 60 && busy == 2'b11) begin
                start = 1'b1;
                h_in  = 9'($urandom_range(0, 300));
                k_in  = 4'($urandom_range(0, 15));
                n_in  = 4'($urandom_range(0, 15));
                @(posedge clk);
                #1;
                start = 1'b0;
                cyc++;
            end
        end
        if (cyc >= 20000) chk("timeout", 0, cyc, 0);
        if (do_stall) chk("stall_seen", 1, stalled, 1);
        accepted++;
        for (int d = 0; d < 2; d++) begin
            chk("done_count", d, done_cnt[d] - b_done[d], 1);
            chk("swap_count", d, swap_cnt[d] - b_swap[d], tiles);
            chk("beat_count", d, beat_cnt[d] - b_beat[d], AD * tiles);
            chk("error_count", d, err_cnt[d] - b_err[d], 0);
        end
        chk("leftover_writes", 0, q0.size(), 0);
        chk("leftover_writes", 1, q1.size(), 0);
    endtask

    task automatic run_reject(input int h, input int k, input int n);
        int b_err [2];
        for (int d = 0; d < 2; d++) b_err[d] = err_cnt[d];
        issue(h, k, n);
        chk("reject_busy", 0, busy, 0);
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) chk("reject_error", d, err_cnt[d] - b_err[d], 1);
        chk("reject_busy_after", 0, busy, 0);
    endtask

    task automatic run_reset_test();
        int b_done [2];
        int cyc;
        for (int d = 0; d < 2; d++) b_done[d] = done_cnt[d];
        push_cmd(32, 0, 0);
        issue(32, 0, 0);
        cyc = 0;
        while (!wr[0] && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 5000) chk("reset_wait_timeout", 0, cyc, 0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_zero(0);
            chk_zero(1);
        end
        rst = 1'b1;
        q0.delete();
        q1.delete();
        repeat (5) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_no_done", d, done_cnt[d] - b_done[d], 0);
            chk("reset_idle", d, longint'({busy[d], ldw[d], mac[d]}), 0);
        end
    endtask

    initial begin
        int h, k, n, hmax;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero(0);
        chk_zero(1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_cmd(32, 0, 0, 1'b0, 1'b0);
        run_cmd(5, 1, 1, 1'b0, 1'b1);
        run_reject(40, 0, 3);
        run_reject(0, 0, 0);
        run_cmd(5, 1, 1, 1'b1, 1'b0);
        run_reset_test();
        run_cmd(97, 0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            k = $urandom_range(0, 3);
            n = $urandom_range(0, 2);
            hmax = DEPTH / (n + 1) - (AD - 1);
            if (i == 3 || i == 6) begin
                h = $urandom_range(hmax + 1, hmax + 40);
                run_reject(h, k, n);
            end else begin
                h = $urandom_range(1, hmax);
                run_cmd(h, k, n, 1'b0, (i == 1));
            end
        end

        chk("total_done", 0, done_cnt[0], accepted);
        chk("total_done", 1, done_cnt[1], accepted);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
